// File: rtl/spi_txn_ctrl_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_ctrl_pkg;

    // Level of an inactive slave-select line.
    localparam logic SS_IDLE = 1'b1;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StStart  = 3'd2,
        StWait   = 3'd3,
        StLatch  = 3'd4,
        StStore  = 3'd5,
        StHold   = 3'd6,
        StFinish = 3'd7
    } state_e;

    // One bit of the active-low one-hot slave-select decode.
    function automatic logic ss_bit_n(input int unsigned sel, input int unsigned bit_idx);
        return (sel == bit_idx) ? ~SS_IDLE : SS_IDLE;
    endfunction

endpackage

// File: rtl/spi_txn_ctrl_if.sv
// Host-side command, buffer-access and status bundle of the SPI transaction sequencer.
interface spi_txn_ctrl_if #(
    parameter int unsigned NUM_SS  = 4,
    parameter int unsigned MAX_LEN = 8
);
    localparam int unsigned SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int unsigned ADDR_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W  = ADDR_W + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_ss_sel;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_cpol;
    logic              cmd_cpha;
    logic              tx_wr_en;
    logic [ADDR_W-1:0] tx_wr_addr;
    logic [7:0]        tx_wr_data;
    logic              tx_wr_err;
    logic [ADDR_W-1:0] rx_rd_addr;
    logic [7:0]        rx_rd_data;
    logic              busy;
    logic              txn_done;

    // Register-file side.
    modport master (
        output cmd_valid, cmd_ss_sel, cmd_len, cmd_cpol, cmd_cpha,
        output tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
        input  cmd_ready, tx_wr_err, rx_rd_data, busy, txn_done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_ss_sel, cmd_len, cmd_cpol, cmd_cpha,
        input  tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
        output cmd_ready, tx_wr_err, rx_rd_data, busy, txn_done
    );
endinterface

// File: rtl/spi_byte_buf.sv
// Byte-wide register array: one synchronous write port, one asynchronous read port.
module spi_byte_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);
    logic [7:0] mem [DEPTH];

    // Storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI burst sequencer sitting between the register file and the byte-wide master.
module spi_txn_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SS   = 4,
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned CS_SETUP = 10,
    parameter int unsigned CS_HOLD  = 10
) (
    input  logic              clk,
    input  logic              reset,
    spi_txn_ctrl_if.slave     host,
    output logic              m_start,
    output logic [7:0]        m_tx_data,
    output logic              m_cpol,
    output logic              m_cpha,
    output logic              m_so_done,
    input  logic              m_ready,
    input  logic              m_done,
    input  logic [7:0]        m_rx_data,
    output logic              m_ss,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int unsigned ADDR_W  = $clog2(MAX_LEN);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [LEN_W-1:0]    len_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmd_ready_q;
    logic                txn_done_q;
    logic                tx_wr_err_q;
    logic                m_start_q;
    logic                m_so_done_q;
    logic [7:0]          m_tx_data_q;
    logic                m_cpol_q;
    logic                m_cpha_q;
    logic                m_ss_q;
    logic [NUM_SS-1:0]   ss_n_q;

    logic                cmd_acc;
    logic                sel_ok;
    logic                last_byte;
    logic                tx_wr_ok;
    logic                rx_wr_en;
    logic [LEN_W-1:0]    len_sat;
    logic [NUM_SS-1:0]   ss_dec_n;
    logic [7:0]          tx_rdata;

    // Command qualification, length saturation and byte-index bookkeeping.
    always_comb begin
        cmd_acc   = (state_q == StIdle) && cmd_ready_q && host.cmd_valid;
        sel_ok    = 32'(host.cmd_ss_sel) < NUM_SS;
        len_sat   = (host.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : host.cmd_len;
        last_byte = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
        tx_wr_ok  = host.tx_wr_en && (state_q == StIdle);
        rx_wr_en  = (state_q == StStore);
    end

    // Active-low select pattern for the requested slave.
    always_comb begin
        ss_dec_n = {NUM_SS{SS_IDLE}};
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            ss_dec_n[i] = ss_bit_n(32'(host.cmd_ss_sel), i);
        end
    end

    spi_byte_buf #(
        .DEPTH (MAX_LEN)
    ) u_tx_buf (
        .clk     (clk),
        .wr_en   (tx_wr_ok),
        .wr_addr (host.tx_wr_addr),
        .wr_data (host.tx_wr_data),
        .rd_addr (idx_q),
        .rd_data (tx_rdata)
    );

    spi_byte_buf #(
        .DEPTH (MAX_LEN)
    ) u_rx_buf (
        .clk     (clk),
        .wr_en   (rx_wr_en),
        .wr_addr (idx_q),
        .wr_data (m_rx_data),
        .rd_addr (host.rx_rd_addr),
        .rd_data (host.rx_rd_data)
    );

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            txn_done_q  <= 1'b0;
            tx_wr_err_q <= 1'b0;
            m_start_q   <= 1'b0;
            m_so_done_q <= 1'b0;
            m_tx_data_q <= '0;
            m_cpol_q    <= 1'b0;
            m_cpha_q    <= 1'b0;
            m_ss_q      <= SS_IDLE;
            ss_n_q      <= {NUM_SS{SS_IDLE}};
        end else begin
            tx_wr_err_q <= host.tx_wr_en && (state_q != StIdle);
            m_start_q   <= 1'b0;
            m_so_done_q <= 1'b0;
            txn_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_acc) begin
                        cmd_ready_q <= 1'b0;
                        len_q       <= len_sat;
                        m_cpol_q    <= host.cmd_cpol;
                        m_cpha_q    <= host.cmd_cpha;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        // Empty or out-of-range requests complete without touching SS.
                        if ((len_sat == '0) || !sel_ok) begin
                            state_q    <= StFinish;
                            txn_done_q <= 1'b1;
                        end else begin
                            state_q <= StSetup;
                            ss_n_q  <= ss_dec_n;
                            m_ss_q  <= ~SS_IDLE;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStart: begin
                    m_tx_data_q <= tx_rdata;
                    if (m_ready) begin
                        m_start_q <= 1'b1;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    m_tx_data_q <= tx_rdata;
                    if (m_done) begin
                        m_so_done_q <= 1'b1;
                        state_q     <= StLatch;
                    end
                end
                StLatch: begin
                    state_q <= StStore;
                end
                StStore: begin
                    idx_q <= idx_q + ADDR_W'(1);
                    if (last_byte) begin
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end else begin
                        state_q <= StStart;
                    end
                end
                StHold: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        ss_n_q     <= {NUM_SS{SS_IDLE}};
                        m_ss_q     <= SS_IDLE;
                        txn_done_q <= 1'b1;
                        state_q    <= StFinish;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StFinish: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The TX byte is presented straight from the buffer while a byte is in flight so it is
    // valid from the first START cycle; the register keeps it stable elsewhere.
    always_comb begin
        m_tx_data = ((state_q == StStart) || (state_q == StWait)) ? tx_rdata : m_tx_data_q;
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.busy      = (state_q != StIdle);
    assign host.txn_done  = txn_done_q;
    assign host.tx_wr_err = tx_wr_err_q;
    assign m_start        = m_start_q;
    assign m_so_done      = m_so_done_q;
    assign m_cpol         = m_cpol_q;
    assign m_cpha         = m_cpha_q;
    assign m_ss           = m_ss_q;
    assign ss_n           = ss_n_q;
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed self-checking bench for the SPI transaction sequencer.
`timescale 1ns/1ps
module tb_spi_txn_ctrl;
    localparam int unsigned NUM_SS   = 4;
    localparam int unsigned MAX_LEN  = 8;
    localparam int unsigned CS_SETUP = 3;
    localparam int unsigned CS_HOLD  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main DUT and its master/slave model.
    spi_txn_ctrl_if #(.NUM_SS(NUM_SS), .MAX_LEN(MAX_LEN)) host_if ();
    logic              m_start, m_cpol, m_cpha, m_so_done, m_ss;
    logic [7:0]        m_tx_data, m_rx_data;
    logic              m_ready, m_done;
    logic [NUM_SS-1:0] ss_n;

    spi_txn_ctrl #(
        .NUM_SS(NUM_SS), .MAX_LEN(MAX_LEN), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .host(host_if),
        .m_start(m_start), .m_tx_data(m_tx_data), .m_cpol(m_cpol), .m_cpha(m_cpha),
        .m_so_done(m_so_done), .m_ready(m_ready), .m_done(m_done), .m_rx_data(m_rx_data),
        .m_ss(m_ss), .ss_n(ss_n)
    );

    // Second DUT with five selects so that an out-of-range index is representable.
    spi_txn_ctrl_if #(.NUM_SS(5), .MAX_LEN(MAX_LEN)) host5 ();
    logic       m_start5, m_cpol5, m_cpha5, m_so_done5, m_ss5;
    logic [7:0] m_tx_data5;
    logic [4:0] ss_n5;
    logic       one5  = 1'b1;
    logic       zero5 = 1'b0;
    logic [7:0] zbyte5 = 8'h00;

    spi_txn_ctrl #(
        .NUM_SS(5), .MAX_LEN(MAX_LEN), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
    ) dut5 (
        .clk(clk), .reset(reset), .host(host5),
        .m_start(m_start5), .m_tx_data(m_tx_data5), .m_cpol(m_cpol5), .m_cpha(m_cpha5),
        .m_so_done(m_so_done5), .m_ready(one5), .m_done(zero5), .m_rx_data(zbyte5),
        .m_ss(m_ss5), .ss_n(ss_n5)
    );

    int tests = 0;
    int fails = 0;

    // Master + slave model: 3 busy cycles after start, then a done pulse.
    logic       echo;
    logic [7:0] resp_fixed, mm_shift, slave_prev, last_tx;
    int         mm_cnt;
    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            mm_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_so_done) m_rx_data <= mm_shift;
            if (m_start && m_ready) begin
                m_ready    <= 1'b0;
                mm_cnt     <= 3;
                mm_shift   <= echo ? slave_prev : resp_fixed;
                slave_prev <= m_tx_data;
                last_tx    <= m_tx_data;
            end else if (!m_ready) begin
                if (mm_cnt == 1) begin
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end
                mm_cnt <= mm_cnt - 1;
            end
        end
    end

    // Event monitor sampling pre-edge values.
    int n_start = 0, n_done = 0, n_err = 0, n_fall = 0, n_rise = 0, ss_bad = 0, n_start5 = 0;
    int cyc = 0, t_fall = 0, t_start = 0, t_so = 0, t_rise = 0;
    logic first_pending = 1'b0;
    logic [NUM_SS-1:0] ss_prev = '1;
    logic [NUM_SS-1:0] exp_ss = '1;
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (m_start) begin
                n_start++;
                if (first_pending) begin
                    t_start = cyc;
                    first_pending = 1'b0;
                end
            end
            if (m_start5) n_start5++;
            if (host_if.txn_done) n_done++;
            if (host_if.tx_wr_err) n_err++;
            if (m_so_done) t_so = cyc;
            if (ss_n != '1 && ss_prev == '1) begin
                n_fall++;
                t_fall = cyc;
                first_pending = 1'b1;
            end
            if (ss_n == '1 && ss_prev != '1) begin
                n_rise++;
                t_rise = cyc;
            end
            if (ss_n != '1 && ss_n != exp_ss) ss_bad++;
        end
        ss_prev = ss_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_tx(input int a, input logic [7:0] d);
        host_if.tx_wr_en   = 1'b1;
        host_if.tx_wr_addr = 3'(a);
        host_if.tx_wr_data = d;
        @(negedge clk);
        host_if.tx_wr_en   = 1'b0;
    endtask

    task automatic issue(input string tag, input int sel, input int len, input logic cpol,
                         input logic cpha);
        chk({tag, "_cmd_ready"}, host_if.cmd_ready, 1);
        host_if.cmd_valid  = 1'b1;
        host_if.cmd_ss_sel = 2'(sel);
        host_if.cmd_len    = 4'(len);
        host_if.cmd_cpol   = cpol;
        host_if.cmd_cpha   = cpha;
        @(negedge clk);
        host_if.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (n_done == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n_done - d0, 1);
    endtask

    task automatic wait_starts(input string tag, input int s0, input int k, input int budget);
        int n = 0;
        while ((n_start - s0) < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'((n_start - s0) >= k), 1);
    endtask

    task automatic chk_rx(input string tag, input int a, input logic [7:0] exp);
        host_if.rx_rd_addr = 3'(a);
        #1;
        chk(tag, host_if.rx_rd_data, exp);
    endtask

    int s0, d0, f0, r0, b0, e0;

    initial begin
        reset = 1'b1;
        host_if.cmd_valid = 1'b0; host_if.cmd_ss_sel = '0; host_if.cmd_len = '0;
        host_if.cmd_cpol = 1'b0; host_if.cmd_cpha = 1'b0; host_if.tx_wr_en = 1'b0;
        host_if.tx_wr_addr = '0; host_if.tx_wr_data = '0; host_if.rx_rd_addr = '0;
        host5.cmd_valid = 1'b0; host5.cmd_ss_sel = '0; host5.cmd_len = '0;
        host5.cmd_cpol = 1'b0; host5.cmd_cpha = 1'b0; host5.tx_wr_en = 1'b0;
        host5.tx_wr_addr = '0; host5.tx_wr_data = '0; host5.rx_rd_addr = '0;
        echo = 1'b0; resp_fixed = 8'h3C; slave_prev = 8'h00; last_tx = 8'h00;
        m_rx_data = 8'h00; mm_shift = 8'h00;
        tick(2);

        // Reset values
        chk("rst_cmd_ready", host_if.cmd_ready, 0);
        chk("rst_busy", host_if.busy, 0);
        chk("rst_ss_n", ss_n, 4'hF);
        chk("rst_m_ss", m_ss, 1);
        chk("rst_outs", {m_start, m_so_done, m_cpol, m_cpha, host_if.txn_done,
                         host_if.tx_wr_err}, 0);
        chk("rst_m_tx_data", m_tx_data, 0);
        chk("rst5_outs", {m_start5, m_so_done5, m_cpol5, m_cpha5, host5.busy,
                          host5.tx_wr_err, host5.txn_done}, 0);
        chk("rst5_data", m_tx_data5, 0);
        reset = 1'b0;
        tick(1);
        chk("rst_cmd_ready_after", host_if.cmd_ready, 1);
        chk("rst5_cmd_ready_after", host5.cmd_ready, 1);

        // Single byte to slave 2
        wr_tx(0, 8'hA5);
        exp_ss = 4'b1011; s0 = n_start; d0 = n_done; f0 = n_fall; r0 = n_rise; b0 = ss_bad;
        issue("t1", 2, 1, 1'b0, 1'b0);
        chk("t1_ss_n", ss_n, 4'b1011);
        chk("t1_m_ss", m_ss, 0);
        chk("t1_busy", host_if.busy, 1);
        chk("t1_cmd_ready_busy", host_if.cmd_ready, 0);
        wait_done("t1_done", d0, 200);
        chk("t1_starts", n_start - s0, 1);
        chk("t1_tx", last_tx, 8'hA5);
        chk_rx("t1_rx0", 0, 8'h3C);
        chk("t1_ss_pattern", ss_bad - b0, 0);
        chk("t1_ss_edges", {16'(n_fall - f0), 16'(n_rise - r0)}, {16'd1, 16'd1});
        chk("t1_ss_idle", {m_ss, ss_n}, 5'h1F);
        chk("t1_cmd_ready_end", host_if.cmd_ready, 1);

        // Four-byte burst, cpha=1, slave echoes the previous byte
        for (int i = 0; i < 4; i++) wr_tx(i, 8'(i + 1));
        echo = 1'b1;
        exp_ss = 4'b1110; s0 = n_start; d0 = n_done; f0 = n_fall; r0 = n_rise; b0 = ss_bad;
        issue("t2", 0, 4, 1'b1, 1'b1);
        chk("t2_mode", {m_cpol, m_cpha}, 2'b11);
        wait_done("t2_done", d0, 300);
        chk("t2_starts", n_start - s0, 4);
        chk("t2_ss_pattern", ss_bad - b0, 0);
        chk("t2_ss_edges", {16'(n_fall - f0), 16'(n_rise - r0)}, {16'd1, 16'd1});
        chk("t2_setup_gap", 32'((t_start - t_fall) >= int'(CS_SETUP)), 1);
        chk("t2_hold_gap", t_rise - t_so, CS_HOLD + 2);
        chk_rx("t2_rx1", 1, 8'h01);
        chk_rx("t2_rx2", 2, 8'h02);
        chk_rx("t2_rx3", 3, 8'h03);
        chk("t2_mode_idle", {m_cpol, m_cpha}, 2'b11);

        // Zero length
        echo = 1'b0;
        s0 = n_start; d0 = n_done; f0 = n_fall;
        issue("t3", 1, 0, 1'b0, 1'b0);
        chk("t3_done_pulse", host_if.txn_done, 1);
        wait_done("t3_done", d0, 2);
        chk("t3_no_start", n_start - s0, 0);
        chk("t3_no_ss", n_fall - f0, 0);
        chk("t3_ss_n", ss_n, 4'hF);

        // Out-of-range select on the five-select instance
        host5.cmd_valid = 1'b1; host5.cmd_ss_sel = 3'd5; host5.cmd_len = 4'd2;
        @(negedge clk);
        host5.cmd_valid = 1'b0;
        chk("t4_done_pulse", host5.txn_done, 1);
        chk("t4_ss_n", {m_ss5, ss_n5}, 6'h3F);
        tick(1);
        chk("t4_done_clear", host5.txn_done, 0);
        chk("t4_ready_back", host5.cmd_ready, 1);
        chk("t4_no_start", n_start5, 0);

        // Write while busy is dropped
        resp_fixed = 8'hC3;
        exp_ss = 4'b0111; s0 = n_start; d0 = n_done; e0 = n_err;
        issue("t5", 3, 1, 1'b0, 1'b0);
        wait_starts("t5_start_seen", s0, 1, 100);
        host_if.tx_wr_en = 1'b1; host_if.tx_wr_addr = '0; host_if.tx_wr_data = 8'hFF;
        @(negedge clk);
        host_if.tx_wr_en = 1'b0;
        chk("t5_wr_err", host_if.tx_wr_err, 1);
        wait_done("t5_done", d0, 200);
        chk("t5_err_count", n_err - e0, 1);
        resp_fixed = 8'h5A; d0 = n_done;
        issue("t5b", 3, 1, 1'b0, 1'b0);
        wait_done("t5b_done", d0, 200);
        chk("t5_txbuf_kept", last_tx, 8'h01);
        chk_rx("t5_rx0", 0, 8'h5A);

        // Reset in WAIT of byte 2
        exp_ss = 4'b1101; s0 = n_start;
        issue("t6", 1, 4, 1'b0, 1'b0);
        wait_starts("t6_start2_seen", s0, 2, 200);
        d0 = n_done;
        reset = 1'b1;
        #1;
        chk("t6_async_ss", {m_ss, ss_n}, 5'h1F);
        chk("t6_busy", host_if.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(3);
        chk("t6_no_done", n_done - d0, 0);
        resp_fixed = 8'h77; s0 = n_start; d0 = n_done;
        issue("t6b", 1, 2, 1'b0, 1'b0);
        wait_done("t6b_done", d0, 200);
        chk("t6b_starts", n_start - s0, 2);
        chk_rx("t6b_rx0", 0, 8'h77);
        chk_rx("t6b_rx1", 1, 8'h77);
        chk_rx("t6b_rx2_kept", 2, 8'h02);

        // Length saturation; byte 0 written in the acceptance cycle
        for (int i = 1; i < 8; i++) wr_tx(i, 8'(8'h10 + i));
        echo = 1'b1;
        exp_ss = 4'b1110; s0 = n_start; d0 = n_done;
        chk("t7_cmd_ready", host_if.cmd_ready, 1);
        host_if.tx_wr_en = 1'b1; host_if.tx_wr_addr = '0; host_if.tx_wr_data = 8'h10;
        host_if.cmd_valid = 1'b1; host_if.cmd_ss_sel = 2'd0; host_if.cmd_len = 4'd15;
        @(negedge clk);
        host_if.tx_wr_en = 1'b0; host_if.cmd_valid = 1'b0;
        wait_done("t7_done", d0, 400);
        chk("t7_starts", n_start - s0, 8);
        chk("t7_last_tx", last_tx, 8'h17);
        chk_rx("t7_rx1", 1, 8'h10);
        chk_rx("t7_rx7", 7, 8'h16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
